// File: rtl/pll_lock_reset_sequencer_if.sv
// Signal bundle between the PLL lock sequencer (master) and the PLL/fabric side (slave).
// Latency: none, wires only.
// No backpressure: level status outputs plus the single-cycle clr_stats pulse.
interface pll_lock_reset_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             pll_locked;
    logic             clr_stats;
    logic             pll_rst;
    logic             sys_rst_n;
    logic             ready;
    logic [CNT_W-1:0] lock_loss_cnt;
    logic             timeout_err;

    modport master (
        input  pll_locked, clr_stats,
        output pll_rst, sys_rst_n, ready, lock_loss_cnt, timeout_err
    );

    modport slave (
        output pll_locked, clr_stats,
        input  pll_rst, sys_rst_n, ready, lock_loss_cnt, timeout_err
    );
endinterface

// File: rtl/pll_lock_reset_sequencer.sv
// PLL reset / lock-qualification sequencer on the reference clock; lock statistics exist only with LOCK_STATS_EN.
// Latency: pll_locked reaches the FSM after SYNC_STAGES cycles; every output is registered and moves with the state.
// No backpressure: status outputs are levels, clr_stats is a synchronous single-cycle pulse.
module pll_lock_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pll_lock_reset_sequencer_if.master  pll_if
);
    localparam int MAX_AB = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int MAX_C  = (MAX_AB > PLL_RST_CYCLES) ? MAX_AB : PLL_RST_CYCLES;
    localparam int TMR_W  = $clog2(MAX_C) + 1;

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that saw lk high counts as the first stable cycle.
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk;
    logic                   pll_rst_q, sys_rst_n_q, ready_q;
    logic                   loss_evt, tmo_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_if.pll_locked};
        end
    end

    assign lk = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        loss_evt = 1'b0;
        tmo_evt  = 1'b0;
        unique case (state_q)
            PLL_RST: begin
                if (timer_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = STABLE;
                end else if (timer_q == TMO_LAST) begin
                    state_d = PLL_RST;
                    tmo_evt = 1'b1;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                end else if (timer_q == STB_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!lk) begin
                    state_d  = PLL_RST;
                    loss_evt = 1'b1;
                end
            end
            default: state_d = PLL_RST;
        endcase
        // RUN has no time limit, so its timer simply holds.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q != RUN) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            timer_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pll_rst_q   <= (state_d == PLL_RST);
            sys_rst_n_q <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign pll_if.pll_rst   = pll_rst_q;
    assign pll_if.sys_rst_n = sys_rst_n_q;
    assign pll_if.ready     = ready_q;

`ifdef LOCK_STATS_EN
    logic [CNT_W-1:0] lock_loss_cnt_q, lock_loss_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    always_comb begin
        lock_loss_cnt_d = lock_loss_cnt_q;
        timeout_err_d   = timeout_err_q;
        if (pll_if.clr_stats) begin
            lock_loss_cnt_d = '0;
            timeout_err_d   = 1'b0;
        end else begin
            if (loss_evt && (lock_loss_cnt_q != '1)) lock_loss_cnt_d = lock_loss_cnt_q + 1'b1;
            if (tmo_evt) timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt_q <= '0;
            timeout_err_q   <= 1'b0;
        end else begin
            lock_loss_cnt_q <= lock_loss_cnt_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign pll_if.lock_loss_cnt = lock_loss_cnt_q;
    assign pll_if.timeout_err   = timeout_err_q;
`else
    logic unused_stats;
    assign unused_stats         = pll_if.clr_stats ^ loss_evt ^ tmo_evt;
    assign pll_if.lock_loss_cnt = '0;
    assign pll_if.timeout_err   = 1'b0;
`endif
endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Directed bench for pll_lock_reset_sequencer: expected output snapshots are queued per cycle and
// checked by a negedge monitor. Stats expectations follow LOCK_STATS_EN (held at 0 when undefined).
module tb_pll_lock_reset_sequencer;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    pll_lock_reset_sequencer_if #(.CNT_W(2)) bus ();

    pll_lock_reset_sequencer #(
        .SYNC_STAGES   (2),
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (64),
        .STABLE_CYCLES (8),
        .CNT_W         (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pll_if(bus)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic        pr;
        logic        sr;
        logic        rd;
        logic [1:0]  cnt;
        logic        te;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] m_cnt;
    logic       m_te;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (cyc=%0d, want end before 2ms)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic expect_at(input int c, input string nm, input logic pr, input logic sr, input logic rd);
        exp_t e;
        int   k;
        e.cyc = c; e.name = nm; e.pr = pr; e.sr = sr; e.rd = rd; e.cnt = m_cnt; e.te = m_te;
        k = sb.size();
        while (k > 0 && sb[k-1].cyc > c) k--;
        sb.insert(k, e);
    endtask

    task automatic model_loss();
`ifdef LOCK_STATS_EN
        if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
`endif
    endtask

    task automatic model_timeout();
`ifdef LOCK_STATS_EN
        m_te = 1'b1;
`endif
    endtask

    task automatic model_clear();
        m_cnt = 2'd0;
        m_te  = 1'b0;
    endtask

    task automatic check_front();
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.cyc != cyc || bus.pll_rst !== e.pr || bus.sys_rst_n !== e.sr || bus.ready !== e.rd ||
                bus.lock_loss_cnt !== e.cnt || bus.timeout_err !== e.te) begin
                n_bad++;
                $display("FAIL %s @cyc %0d (due %0d): got pll_rst=%b sys_rst_n=%b ready=%b cnt=%0d terr=%b, want %b %b %b %0d %b",
                         e.name, cyc, e.cyc, bus.pll_rst, bus.sys_rst_n, bus.ready, bus.lock_loss_cnt,
                         bus.timeout_err, e.pr, e.sr, e.rd, e.cnt, e.te);
            end
        end
    endtask

    // Starting in RUN: drop lock, optionally pulse clr_stats on the edge that sees the loss, re-lock.
    task automatic run_loss(input bit with_clr, input string nm);
        int d;
        d = cyc;
        bus.pll_locked = 1'b0;
        expect_at(d + 2, {nm, "_still_run"}, 1'b0, 1'b1, 1'b1);
        if (with_clr) model_clear();
        else          model_loss();
        expect_at(d + 3, {nm, "_drop"},      1'b1, 1'b0, 1'b0);
        expect_at(d + 6, {nm, "_rst_last"},  1'b1, 1'b0, 1'b0);
        expect_at(d + 7, {nm, "_rst_end"},   1'b0, 1'b0, 1'b0);
        if (with_clr) begin
            wait_cyc(d + 2);
            bus.clr_stats = 1'b1;
            wait_cyc(d + 3);
            bus.clr_stats = 1'b0;
        end
        wait_cyc(d + 8);
        bus.pll_locked = 1'b1;
        expect_at(d + 17, {nm, "_pre_run"},  1'b0, 1'b0, 1'b0);
        expect_at(d + 18, {nm, "_rerun"},    1'b0, 1'b1, 1'b1);
        wait_cyc(d + 18);
    endtask

    initial begin
        int r, l, d, c, p, q2;
        n_cmp = 0;
        n_bad = 0;
        m_cnt = 2'd0;
        m_te  = 1'b0;
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.clr_stats  = 1'b0;
        fork
            forever begin
                @(negedge clk);
                check_front();
            end
        join_none

        // Power-up
        step(3);
        expect_at(cyc, "reset_state", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        r = cyc;
        expect_at(r + 3, "pwr_rst_last", 1'b1, 1'b0, 1'b0);
        expect_at(r + 4, "pwr_rst_end",  1'b0, 1'b0, 1'b0);
        wait_cyc(r + 10);
        bus.pll_locked = 1'b1;
        l = cyc;
        expect_at(l + 9,  "pwr_pre_run", 1'b0, 1'b0, 1'b0);
        expect_at(l + 10, "pwr_run",     1'b0, 1'b1, 1'b1);
        expect_at(l + 20, "pwr_run_hold", 1'b0, 1'b1, 1'b1);
        wait_cyc(l + 20);

        // Loss in RUN, then saturation (5 losses total)
        run_loss(1'b0, "loss1");
        run_loss(1'b0, "loss2");
        run_loss(1'b0, "loss3");
        run_loss(1'b0, "loss4");
        run_loss(1'b0, "loss5");

        // Clear in RUN, then a loss, then a clear coinciding with a loss
        c = cyc;
        expect_at(c, "pre_clr", 1'b0, 1'b1, 1'b1);
        bus.clr_stats = 1'b1;
        model_clear();
        expect_at(c + 1, "clr_run", 1'b0, 1'b1, 1'b1);
        step(1);
        bus.clr_stats = 1'b0;
        run_loss(1'b0, "loss6");
        run_loss(1'b1, "loss_clr");

        // Mid-operation reset while in STABLE, with a nonzero counter
        d = cyc;
        bus.pll_locked = 1'b0;
        model_loss();
        wait_cyc(d + 8);
        bus.pll_locked = 1'b1;
        expect_at(d + 12, "stable_pre_rst", 1'b0, 1'b0, 1'b0);
        wait_cyc(d + 13);
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        model_clear();
        expect_at(d + 13, "async_rst", 1'b1, 1'b0, 1'b0);

        // Timeout with pll_locked held low
        step(2);
        rst_n = 1'b1;
        r = cyc;
        expect_at(r + 67, "tmo_wait_end", 1'b0, 1'b0, 1'b0);
        model_timeout();
        expect_at(r + 68, "tmo_rerst",    1'b1, 1'b0, 1'b0);
        expect_at(r + 71, "tmo_rst_last", 1'b1, 1'b0, 1'b0);
        expect_at(r + 72, "tmo_rst_end",  1'b0, 1'b0, 1'b0);
        expect_at(r + 80, "tmo_sticky",   1'b0, 1'b0, 1'b0);
        wait_cyc(r + 80);
        bus.clr_stats = 1'b1;
        model_clear();
        expect_at(r + 81, "tmo_clr", 1'b0, 1'b0, 1'b0);
        step(1);
        bus.clr_stats = 1'b0;
        expect_at(r + 135, "tmo2_wait_end", 1'b0, 1'b0, 1'b0);
        model_timeout();
        expect_at(r + 136, "tmo2_rerst",    1'b1, 1'b0, 1'b0);
        wait_cyc(r + 137);

        // Unstable lock: 5 high, 3 low, then steady
        rst_n = 1'b0;
        model_clear();
        expect_at(cyc, "rst_clears_terr", 1'b1, 1'b0, 1'b0);
        step(1);
        rst_n = 1'b1;
        r = cyc;
        wait_cyc(r + 10);
        p = cyc;
        bus.pll_locked = 1'b1;
        wait_cyc(p + 5);
        bus.pll_locked = 1'b0;
        expect_at(p + 7, "unst_no_run_a", 1'b0, 1'b0, 1'b0);
        wait_cyc(p + 8);
        bus.pll_locked = 1'b1;
        q2 = cyc;
        expect_at(q2 + 1,  "unst_no_run_b", 1'b0, 1'b0, 1'b0);
        expect_at(q2 + 9,  "unst_pre_run",  1'b0, 1'b0, 1'b0);
        expect_at(q2 + 10, "unst_run",      1'b0, 1'b1, 1'b1);
        expect_at(q2 + 15, "unst_run_hold", 1'b0, 1'b1, 1'b1);
        wait_cyc(q2 + 17);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
